cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_pkg.sv | 17 +
 rtl/sat_counter.sv | 20 ++
 rtl/cache_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared state encoding, base address and cache address field widths
package cache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam int TAG_W        = 10;
    localparam int INDEX_W      = 6;
    localparam int OFFSET_W     = 3;
    localparam int CACHE_ADDR_W = TAG_W + INDEX_W + OFFSET_W;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; once all-ones the count holds instead of wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through, no-write-allocate cache controller in front of an SRAM
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic [31:0]             address,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic [CACHE_ADDR_W-1:0] cache_address,
    output logic                    cache_read_en,
    input  logic                    cache_hit,
    input  logic [31:0]             cache_read_data,
    output logic                    cache_fill_en,
    output logic [63:0]             cache_fill_data,
    output logic                    cache_invalidate_en,
    output logic                    sram_r_en,
    output logic                    sram_w_en,
    output logic [31:0]             sram_address,
    output logic [31:0]             sram_wdata,
    input  logic [63:0]             sram_rdata,
    input  logic                    sram_ready,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count
);

    state_t      state;
    state_t      next_state;
    logic [31:0] offset_addr;
    logic        hit_inc;
    logic        miss_inc;

    assign offset_addr     = address - BASE_ADDR;
    assign cache_address   = offset_addr[CACHE_ADDR_W-1:0];
    assign cache_fill_data = sram_rdata;
    assign sram_wdata      = wdata;
    // Line reads fetch the whole 64-bit line, so drop the in-line byte offset.
    assign sram_address    = (state == READ_MISS) ? {offset_addr[31:3], 3'b000} : offset_addr;

    // State register; reset abandons any in-flight miss or write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a store always wins over a simultaneous load.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_w_en) begin
                    next_state = WRITE;
                end else if (mem_r_en && !cache_hit) begin
                    next_state = READ_MISS;
                end
            end
            READ_MISS: begin
                if (sram_ready) begin
                    next_state = IDLE;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode; the cache is only looked up from IDLE so a miss leaves LRU untouched.
    always_comb begin
        ready               = 1'b0;
        rdata               = '0;
        cache_read_en       = 1'b0;
        cache_fill_en       = 1'b0;
        cache_invalidate_en = 1'b0;
        sram_r_en           = 1'b0;
        sram_w_en           = 1'b0;
        hit_inc             = 1'b0;
        miss_inc            = 1'b0;
        case (state)
            IDLE: begin
                if (mem_w_en) begin
                    cache_invalidate_en = 1'b1;
                end else if (mem_r_en) begin
                    cache_read_en = 1'b1;
                    if (cache_hit) begin
                        ready   = 1'b1;
                        rdata   = cache_read_data;
                        hit_inc = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            READ_MISS: begin
                sram_r_en = 1'b1;
                if (sram_ready) begin
                    cache_fill_en = 1'b1;
                    ready         = 1'b1;
                    rdata         = cache_address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                ready     = sram_ready;
            end
            default: ;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_hit_counter (
        .clk   (clk),
        .clr   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_counter (
        .clk   (clk),
        .clr   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule
